// File: rtl/sm83_pkg.sv
// Shared SM83 decode definitions.
//   op_class_e : instruction class carried in each decoded record
//   dec_rec_t  : 33-bit record stored in the decode FIFO
//   op_len     : total byte length of a base-page opcode (1..3)
//   op_class   : class of a base-page opcode
package sm83_pkg;

  typedef enum logic [3:0] {
    CLS_ALU_R    = 4'd0,
    CLS_ALU_N    = 4'd1,
    CLS_INCDEC8  = 4'd2,
    CLS_ROT_MISC = 4'd3,
    CLS_ARITH16  = 4'd4,
    CLS_LD_RR    = 4'd5,
    CLS_LD_RN    = 4'd6,
    CLS_LD_MEM   = 4'd7,
    CLS_LD16     = 4'd8,
    CLS_PUSHPOP  = 4'd9,
    CLS_JUMP     = 4'd10,
    CLS_CALL_RET = 4'd11,
    CLS_CTRL     = 4'd12,
    CLS_CB       = 4'd13,
    CLS_INTR     = 4'd14,
    CLS_ILLEGAL  = 4'd15
  } op_class_e;

  // tag is set on every written entry so a cleared slot never reads as valid
  typedef struct packed {
    logic        tag;
    op_class_e   cls;
    logic [7:0]  opcode;
    logic        bank_cb;
    logic        intr;
    logic [15:0] imm;
    logic [1:0]  len;
  } dec_rec_t;

  localparam int unsigned REC_W = $bits(dec_rec_t);

  // Decoded on the x/y/z opcode fields: x=op[7:6], y=op[5:3], z=op[2:0]
  function automatic logic [1:0] op_len(input logic [7:0] op, input logic stop_len2);
    logic [1:0] x;
    logic [2:0] y;
    logic [2:0] z;
    logic [1:0] n;
    x = op[7:6];
    y = op[5:3];
    z = op[2:0];
    n = 2'd1;
    if (z == 3'd6 && (x == 2'd0 || x == 2'd3)) begin
      n = 2'd2;
    end else if (x == 2'd0) begin
      if (z == 3'd0) begin
        if (y == 3'd1)      n = 2'd3;
        else if (y == 3'd2) n = stop_len2 ? 2'd2 : 2'd1;
        else if (y >= 3'd3) n = 2'd2;
      end else if (z == 3'd1 && !op[3]) begin
        n = 2'd3;
      end
    end else if (x == 2'd3) begin
      case (z)
        3'd0:    if (y[2]) n = 2'd2;
        3'd2:    if (!y[2] || y[0]) n = 2'd3;
        3'd3:    if (y == 3'd0) n = 2'd3;
        3'd4:    if (!y[2]) n = 2'd3;
        3'd5:    if (y == 3'd1) n = 2'd3;
        default: ;
      endcase
    end
    return n;
  endfunction

  function automatic op_class_e op_class(input logic [7:0] op);
    logic [2:0] y;
    op_class_e  c;
    y = op[5:3];
    c = CLS_ILLEGAL;
    case (op[7:6])
      2'd0: begin
        case (op[2:0])
          3'd0: begin
            if (y == 3'd0 || y == 3'd2) c = CLS_CTRL;
            else if (y == 3'd1)         c = CLS_LD16;
            else                        c = CLS_JUMP;
          end
          3'd1:       c = op[3] ? CLS_ARITH16 : CLS_LD16;
          3'd2:       c = CLS_LD_MEM;
          3'd3:       c = CLS_ARITH16;
          3'd4, 3'd5: c = CLS_INCDEC8;
          3'd6:       c = CLS_LD_RN;
          default:    c = CLS_ROT_MISC;
        endcase
      end
      2'd1: c = (op == 8'h76) ? CLS_CTRL : CLS_LD_RR;
      2'd2: c = CLS_ALU_R;
      default: begin
        case (op[2:0])
          3'd0: begin
            if (!y[2])          c = CLS_CALL_RET;
            else if (!y[0])     c = CLS_LD_MEM;
            else if (y == 3'd5) c = CLS_ARITH16;
            else                c = CLS_LD16;
          end
          3'd1: begin
            if (!op[3])         c = CLS_PUSHPOP;
            else if (!y[2])     c = CLS_CALL_RET;
            else if (y == 3'd5) c = CLS_JUMP;
            else                c = CLS_LD16;
          end
          3'd2: c = y[2] ? CLS_LD_MEM : CLS_JUMP;
          3'd3: begin
            if (y == 3'd0)                  c = CLS_JUMP;
            else if (y == 3'd1)             c = CLS_CB;
            else if (y == 3'd6 || y == 3'd7) c = CLS_CTRL;
            else                            c = CLS_ILLEGAL;
          end
          3'd4: c = y[2] ? CLS_ILLEGAL : CLS_CALL_RET;
          3'd5: begin
            if (!op[3])         c = CLS_PUSHPOP;
            else if (y == 3'd1) c = CLS_CALL_RET;
            else                c = CLS_ILLEGAL;
          end
          3'd6:    c = CLS_ALU_N;
          default: c = CLS_CALL_RET;
        endcase
      end
    endcase
    return c;
  endfunction

endpackage

// File: rtl/sm83_dec_fifo.sv
// Decoded-record FIFO, DEPTH entries of WIDTH bits.
//   push/push_data : enqueue a record
//   pop            : dequeue the head record
//   flush          : synchronous clear of occupancy and pointers
//   head           : registered head entry
//   count / full   : occupancy and count==DEPTH
module sm83_dec_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 33
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [2:0]       count,
  output logic             full
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // explicit wrap so non-power-of-two depths stay in range
  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full    = (count == 3'(DEPTH));
  assign do_pop  = pop && (count != 3'd0);
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= bump(wr_ptr);
      end
      if (do_pop) rd_ptr <= bump(rd_ptr);
      if (do_push && !do_pop)      count <= count + 3'd1;
      else if (!do_push && do_pop) count <= count - 3'd1;
    end
  end

endmodule

// File: rtl/sm83_decode_queue.sv
// SM83 instruction assembler and decode queue.
//   byte_valid/byte_data/byte_ready : fetch byte stream
//   intr_req                        : interrupt entry, taken at instruction boundary
//   flush                           : drop partial instruction and queued records
//   out_valid/out_ready             : decoded record handshake
//   out_class/opcode/bank_cb/intr/imm/len : head record fields
//   out_count                       : queued record count
module sm83_decode_queue
  import sm83_pkg::*;
#(
  parameter int unsigned OUT_DEPTH = 2,
  parameter int unsigned STOP_LEN2 = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  input  logic        intr_req,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_class,
  output logic [7:0]  out_opcode,
  output logic        out_bank_cb,
  output logic        out_intr,
  output logic [15:0] out_imm,
  output logic [1:0]  out_len,
  output logic [2:0]  out_count
);

  typedef enum logic [1:0] {ST_OPC, ST_CB_OPC, ST_IMM_LO, ST_IMM_HI} asm_state_e;

  localparam logic STOP2 = (STOP_LEN2 != 0);

  asm_state_e       state_q, state_d;
  logic [7:0]       op_q;
  logic [7:0]       imm_lo_q;
  logic             need2_q;
  logic [1:0]       byte_len;
  logic             completes;
  logic             intr_take;
  logic             byte_fire;
  logic             push;
  logic             pop;
  logic             fifo_full;
  logic [2:0]       fifo_count;
  logic [REC_W-1:0] head_bits;
  dec_rec_t         push_rec;
  dec_rec_t         head_rec;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   state_q <= ST_OPC;
    else if (flush) state_q <= ST_OPC;
    else            state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q     <= '0;
      imm_lo_q <= '0;
      need2_q  <= 1'b0;
    end else if (byte_fire) begin
      if (state_q == ST_OPC) begin
        op_q    <= byte_data;
        need2_q <= (byte_len == 2'd3);
      end
      if (state_q == ST_IMM_LO) imm_lo_q <= byte_data;
    end
  end

  always_comb begin
    state_d = state_q;
    if (byte_fire) begin
      case (state_q)
        ST_OPC: begin
          if (byte_data == 8'hCB)    state_d = ST_CB_OPC;
          else if (byte_len != 2'd1) state_d = ST_IMM_LO;
        end
        ST_IMM_LO: state_d = need2_q ? ST_IMM_HI : ST_OPC;
        default:   state_d = ST_OPC;
      endcase
    end
  end

  always_comb begin
    byte_len  = op_len(byte_data, STOP2);
    completes = 1'b0;
    case (state_q)
      ST_OPC:    completes = (byte_data != 8'hCB) && (byte_len == 2'd1);
      ST_IMM_LO: completes = !need2_q;
      default:   completes = 1'b1;
    endcase
    intr_take  = !flush && (state_q == ST_OPC) && intr_req && !fifo_full;
    // a completing byte is refused while full even if a pop is under way
    byte_ready = reset_n && !flush && !((state_q == ST_OPC) && intr_req) &&
                 !(completes && fifo_full);
    byte_fire  = byte_valid && byte_ready;
    push       = intr_take || (byte_fire && completes);

    push_rec     = '0;
    push_rec.tag = 1'b1;
    if (intr_take) begin
      push_rec.cls  = CLS_INTR;
      push_rec.intr = 1'b1;
    end else begin
      case (state_q)
        ST_OPC: begin
          push_rec.cls    = op_class(byte_data);
          push_rec.opcode = byte_data;
          push_rec.len    = 2'd1;
        end
        ST_CB_OPC: begin
          push_rec.cls     = CLS_CB;
          push_rec.opcode  = byte_data;
          push_rec.bank_cb = 1'b1;
          push_rec.len     = 2'd2;
        end
        ST_IMM_LO: begin
          push_rec.cls    = op_class(op_q);
          push_rec.opcode = op_q;
          push_rec.imm    = {8'h00, byte_data};
          push_rec.len    = 2'd2;
        end
        default: begin
          push_rec.cls    = op_class(op_q);
          push_rec.opcode = op_q;
          push_rec.imm    = {byte_data, imm_lo_q};
          push_rec.len    = 2'd3;
        end
      endcase
    end
  end

  sm83_dec_fifo #(
    .DEPTH (OUT_DEPTH),
    .WIDTH (REC_W)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .push      (push),
    .push_data (push_rec),
    .pop       (pop),
    .head      (head_bits),
    .count     (fifo_count),
    .full      (fifo_full)
  );

  assign head_rec    = dec_rec_t'(head_bits);
  assign out_valid   = (fifo_count != 3'd0) && head_rec.tag;
  assign pop         = out_valid && out_ready;
  assign out_class   = head_rec.cls;
  assign out_opcode  = head_rec.opcode;
  assign out_bank_cb = head_rec.bank_cb;
  assign out_intr    = head_rec.intr;
  assign out_imm     = head_rec.imm;
  assign out_len     = head_rec.len;
  assign out_count   = fifo_count;

endmodule

// File: doc/sm83_decode_queue.md
SM83_DECODE_QUEUE -- requirements
Module: sm83_decode_queue

Interface
REQ-001 SHALL have parameter OUT_DEPTH, default 2, decoded-record FIFO depth (legal 1..4).
REQ-002 SHALL have parameter STOP_LEN2, default 1: 1 = STOP (10h) consumes 2 bytes, 0 = 1 byte.
REQ-003 SHALL have port clk  in  1  sole clock, rising edge.
REQ-004 SHALL have port reset_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have ports byte_valid in 1 / byte_data in 8 / byte_ready out 1  fetch byte stream, transfer on valid&&ready.
REQ-006 SHALL have port intr_req  in  1  interrupt-entry request, sampled only at instruction boundary.
REQ-007 SHALL have port flush  in  1  synchronous discard of partial instruction and FIFO.
REQ-008 SHALL have ports out_valid out 1 / out_ready in 1  record handshake, pop on valid&&ready.
REQ-009 SHALL have ports out_class out 4 (class enum), out_opcode out 8, out_bank_cb out 1, out_intr out 1, out_imm out 16, out_len out 2 (bytes consumed, 0..3).
REQ-010 SHALL have port out_count  out  3  current FIFO occupancy.

Function
REQ-011 SHALL use assembler states OPC, CB_OPC, IMM_LO, IMM_HI.
REQ-012 OPC: accepted byte CBh -> CB_OPC; 1-byte opcode -> enqueue, stay OPC; 2-byte -> IMM_LO (need 1); 3-byte -> IMM_LO (need 2).
REQ-013 2-byte opcodes: 00xxx110, 11xxx110, 18/20/28/30/38, E0/F0/E8/F8, 10 when STOP_LEN2=1; 3-byte: 01/11/21/31/08, C2/C3/C4/CA/CC/CD/D2/D4/DA/DC, EA/FA; all others 1 byte.
REQ-014 CB_OPC: next accepted byte enqueued with out_bank_cb=1, class CB, out_len=2, out_imm=0; -> OPC.
REQ-015 IMM_LO: byte stored in imm[7:0]; if need 1 -> enqueue with imm[15:8]=00h, else -> IMM_HI; IMM_HI: byte stored in imm[15:8], enqueue, -> OPC.
REQ-016 Classification: ALU_R, ALU_N, INCDEC8, ROT_MISC (07/0F/17/1F/27/2F/37/3F), ARITH16, LD_RR, LD_RN, LD_MEM, LD16, PUSHPOP, JUMP (JP/JR/JP HL), CALL_RET (CALL/RET/RETI/RST), CTRL (00/10/76/F3/FB), CB, INTR, ILLEGAL.
REQ-017 ILLEGAL for D3/DB/DD/E3/E4/EB/EC/ED/F4/FC/FD; length 1; HALT (76h) SHALL be CTRL, not LD_RR.
REQ-018 Interrupt: in OPC with intr_req=1 and FIFO not full, enqueue class INTR, out_intr=1, out_len=0, out_opcode=00h; byte_ready=0 that cycle; intr_req ignored in other states.
REQ-019 byte_ready = !flush && !(state OPC && intr_req) && !(byte would complete record && FIFO full); full = count==OUT_DEPTH, no pop-through bypass.
REQ-020 Simultaneous push and pop on full or non-empty FIFO SHALL both occur; count unchanged.
REQ-021 out_valid = count!=0; out_* show head record, registered, stable while out_valid&&!out_ready.
REQ-022 flush SHALL take priority over all: next cycle state OPC, count 0, out_valid 0; byte and intr in flush cycle dropped.
REQ-023 Record latency: enqueue on the edge accepting the final byte; out_valid high the following cycle.
REQ-024 FIFO pointers SHALL wrap modulo OUT_DEPTH for non-power-of-two depths.

Reset
REQ-025 reset_n low: state OPC, count 0, pointers 0, imm 0, out_valid 0, out_* 0, byte_ready 0 while asserted.
REQ-026 Reset mid-instruction SHALL discard partial bytes; first byte after release decoded as opcode.

Structure
REQ-027 Class enum, opcode length function, and classification function SHALL live in package sm83_pkg.
REQ-028 FIFO SHALL be sub-module sm83_dec_fifo (parameter DEPTH, WIDTH=33 bits record).

Verification
REQ-029 Stream 3E 42 -> one record class LD_RN, opcode 3E, imm 0042h, len 2.
REQ-030 Stream CD 34 12 with out_ready=0, OUT_DEPTH=2, then 00 00 -> two records held, byte_ready 0 on third complete; CALL_RET imm 1234h first out.
REQ-031 Stream CB 37 -> bank_cb 1, class CB, opcode 37h, len 2; then 37 -> ROT_MISC, bank_cb 0.
REQ-032 intr_req=1 and byte_valid 00h same OPC cycle -> INTR record len 0 first, 00h accepted next cycle.
REQ-033 Stream C3 then flush, then 00 -> no JUMP record; single CTRL record opcode 00h.
REQ-034 Stream D3, then 10 00 with STOP_LEN2=1 -> ILLEGAL len 1, CTRL opcode 10h len 2 imm 0000h.
